// File: rtl/kernel_psum_acc_pkg.sv
// Shared constants for the kernel partial-sum accumulator: parameter defaults,
// FSM state encoding and error-register bit positions.
package kernel_psum_acc_pkg;

   localparam int unsigned DEF_BIT_WIDTH  = 8;
   localparam int unsigned DEF_NUM_KERNEL = 4;
   localparam int unsigned DEF_ACC_WIDTH  = 20;
   localparam int unsigned DEF_LEN_WIDTH  = 16;
   localparam int unsigned DEF_REG_WIDTH  = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } psum_acc_state_e;

   localparam int unsigned ERR_PARTIAL_VAL = 0;
   localparam int unsigned ERR_OVERRUN     = 1;
   localparam int unsigned ERR_SAT         = 2;

endpackage

// File: rtl/psum_acc_lane.sv
// One kernel lane: sign-extends the incoming psum, loads or adds it into the lane
// accumulator, and (with PSUM_ACC_SAT_EN defined) clamps and flags saturation.
module psum_acc_lane
   import kernel_psum_acc_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_en,
   input  logic                 i_load,
   input  logic [BIT_WIDTH-1:0] i_psum,
   output logic [ACC_WIDTH-1:0] o_sum,
   output logic                 o_sat
);

   logic [ACC_WIDTH-1:0] r_acc;
   logic [ACC_WIDTH-1:0] w_ext;
   logic [ACC_WIDTH-1:0] w_next;

   assign w_ext = ACC_WIDTH'($signed(i_psum));

`ifdef PSUM_ACC_SAT_EN
   logic [ACC_WIDTH:0] w_wide;
   logic               w_ovf;

   // One guard bit: overflow when the two top bits of the widened sum disagree.
   assign w_wide = {r_acc[ACC_WIDTH-1], r_acc} + {w_ext[ACC_WIDTH-1], w_ext};
   assign w_ovf  = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];

   always_comb begin
      w_next = w_wide[ACC_WIDTH-1:0];
      o_sat  = 1'b0;
      if (i_load) begin
         w_next = w_ext;
      end else if (w_ovf) begin
         o_sat  = i_en;
         w_next = w_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
   end
`else
   assign w_next = i_load ? w_ext : r_acc + w_ext;
   assign o_sat  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= w_next;
      end
   end

   // Next value is exported so the top can capture a finished sum on its final beat.
   assign o_sum = w_next;

endmodule

// File: rtl/kernel_psum_acc.sv
// Accumulates per-kernel psum beats into wide sums and hands results downstream
// over valid/ready; PSUM_ACC_SAT_EN selects saturating instead of wrapping adds.
module kernel_psum_acc
   import kernel_psum_acc_pkg::*;
#(
   parameter int unsigned BIT_WIDTH  = DEF_BIT_WIDTH,
   parameter int unsigned NUM_KERNEL = DEF_NUM_KERNEL,
   parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
   parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [LEN_WIDTH-1:0]            i_cfg_len,
   input  logic [BIT_WIDTH*NUM_KERNEL-1:0] i_psum,
   input  logic [NUM_KERNEL-1:0]           i_psum_val,
   output logic [ACC_WIDTH*NUM_KERNEL-1:0] o_acc,
   output logic                            o_acc_val,
   input  logic                            i_acc_rdy,
   output logic                            o_busy,
   output logic [REG_WIDTH-1:0]            err_psum_val
);

   psum_acc_state_e r_state, w_state_nxt;

   logic [LEN_WIDTH-1:0] r_cnt, r_len;
   logic [LEN_WIDTH-1:0] w_cnt_nxt, w_len_nxt;
   logic [LEN_WIDTH-1:0] w_cfg_len, w_cnt_inc;

   logic w_beat, w_partial, w_load, w_done, w_hs, w_overrun;

   logic [ACC_WIDTH*NUM_KERNEL-1:0] w_sum;
   logic [NUM_KERNEL-1:0]           w_lane_sat;

   logic [ACC_WIDTH*NUM_KERNEL-1:0] r_acc_out;
   logic                            r_acc_val;
   logic [2:0]                      r_err;

   assign w_beat    = &i_psum_val;
   assign w_partial = (|i_psum_val) && !w_beat;
   assign w_cfg_len = (i_cfg_len == '0) ? LEN_WIDTH'(1) : i_cfg_len;
   assign w_cnt_inc = r_cnt + LEN_WIDTH'(1);

   for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
      psum_acc_lane #(
         .BIT_WIDTH (BIT_WIDTH),
         .ACC_WIDTH (ACC_WIDTH)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .i_en   (w_beat),
         .i_load (w_load),
         .i_psum (i_psum[BIT_WIDTH*k +: BIT_WIDTH]),
         .o_sum  (w_sum[ACC_WIDTH*k +: ACC_WIDTH]),
         .o_sat  (w_lane_sat[k])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_len   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_len   <= w_len_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_len_nxt   = r_len;
      w_load      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_beat) begin
               w_load    = 1'b1;
               w_cnt_nxt = LEN_WIDTH'(1);
               w_len_nxt = w_cfg_len;
               if (w_cfg_len == LEN_WIDTH'(1)) begin
                  w_done = 1'b1;
               end else begin
                  w_state_nxt = ST_ACC;
               end
            end
         end
         ST_ACC: begin
            if (w_beat) begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == r_len) begin
                  w_done      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // A completion coinciding with a handshake refills the slot; only a stalled slot overruns.
   assign w_hs      = r_acc_val && i_acc_rdy;
   assign w_overrun = w_done && r_acc_val && !i_acc_rdy;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_acc_out <= '0;
         r_acc_val <= 1'b0;
         r_err     <= '0;
      end else begin
         if (w_done && !w_overrun) begin
            r_acc_out <= w_sum;
            r_acc_val <= 1'b1;
         end else if (w_hs) begin
            r_acc_out <= '0;
            r_acc_val <= 1'b0;
         end
         if (w_partial) r_err[ERR_PARTIAL_VAL] <= 1'b1;
         if (w_overrun) r_err[ERR_OVERRUN]     <= 1'b1;
         if (|w_lane_sat) r_err[ERR_SAT]       <= 1'b1;
      end
   end

   assign o_acc        = r_acc_out;
   assign o_acc_val    = r_acc_val;
   assign o_busy       = (r_state == ST_ACC);
   assign err_psum_val = {{(REG_WIDTH-3){1'b0}}, r_err};

endmodule

// File: tb/tb_kernel_psum_acc.sv
// Self-checking bench for kernel_psum_acc: directed scenarios plus randomized traffic
// against an integer-arithmetic group-sum reference model.
module tb_kernel_psum_acc;

   localparam int BW   = 8;
   localparam int NK   = 4;
   localparam int AW   = 20;
   localparam int AW10 = 10;
   localparam int LW   = 16;
   localparam int RW   = 32;
   localparam longint AMAX = (64'sd1 <<< (AW - 1)) - 64'sd1;
   localparam longint AMIN = -(64'sd1 <<< (AW - 1));

   logic              clk = 1'b0;
   logic              rst;
   logic [LW-1:0]     i_cfg_len;
   logic [BW*NK-1:0]  i_psum;
   logic [NK-1:0]     i_psum_val;
   logic              i_acc_rdy;
   logic [AW*NK-1:0]  o_acc;
   logic              o_acc_val;
   logic              o_busy;
   logic [RW-1:0]     err;
   logic [AW10*NK-1:0] o_acc10;
   logic              o_acc_val10;
   logic              o_busy10;
   logic [RW-1:0]     err10;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int               m_len, m_cnt;
   bit               m_busy, m_val;
   longint           m_sum [NK];
   logic [AW*NK-1:0] m_acc;
   logic [RW-1:0]    m_err;

   always #5 clk = ~clk;

   kernel_psum_acc #(
      .BIT_WIDTH (BW), .NUM_KERNEL (NK), .ACC_WIDTH (AW), .LEN_WIDTH (LW), .REG_WIDTH (RW)
   ) dut (
      .clk (clk), .rst (rst), .i_cfg_len (i_cfg_len), .i_psum (i_psum), .i_psum_val (i_psum_val),
      .o_acc (o_acc), .o_acc_val (o_acc_val), .i_acc_rdy (i_acc_rdy), .o_busy (o_busy),
      .err_psum_val (err)
   );

   kernel_psum_acc #(
      .BIT_WIDTH (BW), .NUM_KERNEL (NK), .ACC_WIDTH (AW10), .LEN_WIDTH (LW), .REG_WIDTH (RW)
   ) dut10 (
      .clk (clk), .rst (rst), .i_cfg_len (i_cfg_len), .i_psum (i_psum), .i_psum_val (i_psum_val),
      .o_acc (o_acc10), .o_acc_val (o_acc_val10), .i_acc_rdy (i_acc_rdy), .o_busy (o_busy10),
      .err_psum_val (err10)
   );

   function automatic logic [BW*NK-1:0] rep(input logic [BW-1:0] v);
      logic [BW*NK-1:0] r;
      for (int k = 0; k < NK; k++) r[k*BW +: BW] = v;
      return r;
   endfunction

   function automatic logic [AW*NK-1:0] rep_acc(input longint v);
      logic [63:0]      t;
      logic [AW*NK-1:0] r;
      t = v;
      for (int k = 0; k < NK; k++) r[k*AW +: AW] = t[AW-1:0];
      return r;
   endfunction

   // Group-level reference: a group is the sum of len full beats; results go to a one-deep slot.
   task automatic model_step(input bit rstn, input logic [LW-1:0] cfg, input logic [BW*NK-1:0] ps,
                             input logic [NK-1:0] pv, input bit rdy);
      bit          done;
      longint      x, s;
      logic [63:0] t;
      if (!rstn) begin
         m_len = 0; m_cnt = 0; m_busy = 0; m_val = 0; m_acc = '0; m_err = '0;
         for (int k = 0; k < NK; k++) m_sum[k] = 0;
         return;
      end
      done = 0;
      if (pv == '1) begin
         if (!m_busy) begin
            m_cnt = 0;
            m_len = (cfg == 0) ? 1 : int'(cfg);
         end
         for (int k = 0; k < NK; k++) begin
            x = longint'($signed(ps[k*BW +: BW]));
            s = m_busy ? m_sum[k] + x : x;
`ifdef PSUM_ACC_SAT_EN
            if (s > AMAX) begin s = AMAX; m_err[2] = 1'b1; end
            else if (s < AMIN) begin s = AMIN; m_err[2] = 1'b1; end
`endif
            m_sum[k] = s;
         end
         m_cnt++;
         if (m_cnt == m_len) begin done = 1; m_busy = 0; end
         else m_busy = 1;
      end else if (pv != '0) begin
         m_err[0] = 1'b1;
      end
      if (done) begin
         if (m_val && !rdy) m_err[1] = 1'b1;
         else begin
            m_val = 1;
            for (int k = 0; k < NK; k++) begin
               t = m_sum[k];
               m_acc[k*AW +: AW] = t[AW-1:0];
            end
         end
      end else if (m_val && rdy) begin
         m_val = 0;
         m_acc = '0;
      end
   endtask

   task automatic cycle(input bit rstn, input logic [LW-1:0] cfg, input logic [BW*NK-1:0] ps,
                        input logic [NK-1:0] pv, input bit rdy);
      rst = rstn; i_cfg_len = cfg; i_psum = ps; i_psum_val = pv; i_acc_rdy = rdy;
      model_step(rstn, cfg, ps, pv, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cycle(0, 16'd5, rep(8'h11), '1, 1);
      cycle(0, 16'd5, rep(8'h11), '1, 1);
      n_checks++;
      if (o_acc_val !== 1'b0 || o_busy !== 1'b0 || o_acc !== '0 || err !== '0) begin
         n_fail++;
         $display("FAIL reset: got val=%b busy=%b acc=%h err=%h want all zero", o_acc_val, o_busy, o_acc, err);
      end
   endtask

   task automatic test_sum3();
      cycle(0, '0, '0, '0, 1);
      for (int b = 1; b <= 3; b++) begin
         cycle(1, 16'd3, rep(BW'(b)), '1, 1);
         n_checks++;
         if (o_busy !== logic'(b < 3) || o_acc_val !== logic'(b == 3)) begin
            n_fail++;
            $display("FAIL sum3_ctl beat%0d: got busy=%b val=%b want busy=%b val=%b", b, o_busy, o_acc_val, b < 3, b == 3);
         end
      end
      n_checks++;
      if (o_acc !== rep_acc(6) || o_acc !== m_acc) begin
         n_fail++;
         $display("FAIL sum3_acc: got %h want %h", o_acc, rep_acc(6));
      end
      cycle(1, 16'd3, '0, '0, 1);
      n_checks++;
      if (o_acc_val !== 1'b0) begin
         n_fail++;
         $display("FAIL sum3_drain: got val=%b want 0", o_acc_val);
      end
   endtask

   task automatic test_negative();
      logic [AW*NK-1:0] e;
      e = {20'd4, 20'd4, 20'hFFFFC, 20'd4};
      cycle(0, '0, '0, '0, 1);
      for (int b = 1; b <= 4; b++) begin
         cycle(1, 16'd4, {8'h01, 8'h01, 8'hFF, 8'h01}, '1, 1);
         n_checks++;
         if (o_busy !== logic'(b < 4)) begin
            n_fail++;
            $display("FAIL neg_busy beat%0d: got %b want %b", b, o_busy, b < 4);
         end
      end
      n_checks++;
      if (o_acc_val !== 1'b1 || o_acc !== e) begin
         n_fail++;
         $display("FAIL neg_acc: got val=%b acc=%h want val=1 acc=%h", o_acc_val, o_acc, e);
      end
   endtask

   task automatic test_overrun();
      cycle(0, '0, '0, '0, 0);
      cycle(1, 16'd1, rep(8'd5), '1, 0);
      n_checks++;
      if (o_acc_val !== 1'b1 || o_acc !== rep_acc(5)) begin
         n_fail++;
         $display("FAIL ovr_first: got val=%b acc=%h want val=1 acc=%h", o_acc_val, o_acc, rep_acc(5));
      end
      cycle(1, 16'd1, rep(8'd7), '1, 0);
      n_checks++;
      if (o_acc !== rep_acc(5) || err[1] !== 1'b1 || err !== m_err) begin
         n_fail++;
         $display("FAIL ovr_hold: got acc=%h err=%h want acc=%h err=%h", o_acc, err, rep_acc(5), m_err);
      end
      cycle(1, 16'd1, '0, '0, 1);
      n_checks++;
      if (o_acc_val !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_release: got val=%b want 0", o_acc_val);
      end
   endtask

   task automatic test_partial();
      cycle(0, '0, '0, '0, 1);
      cycle(1, 16'd2, rep(8'd3), '1, 1);
      cycle(1, 16'd2, rep(8'd9), 4'b0111, 1);
      n_checks++;
      if (err !== 32'h1 || o_busy !== 1'b1 || o_acc_val !== 1'b0) begin
         n_fail++;
         $display("FAIL partial_flag: got err=%h busy=%b val=%b want err=1 busy=1 val=0", err, o_busy, o_acc_val);
      end
      cycle(1, 16'd2, rep(8'd4), '1, 1);
      n_checks++;
      if (o_acc_val !== 1'b1 || o_acc !== rep_acc(7)) begin
         n_fail++;
         $display("FAIL partial_sum: got val=%b acc=%h want val=1 acc=%h", o_acc_val, o_acc, rep_acc(7));
      end
   endtask

   task automatic test_saturation();
      logic [AW10*NK-1:0] e10;
      logic [RW-1:0]      e_err10;
`ifdef PSUM_ACC_SAT_EN
      e10 = {30'd0, 10'd511};
      e_err10 = 32'h4;
`else
      e10 = {30'd0, 10'd119};
      e_err10 = 32'h0;
`endif
      cycle(0, '0, '0, '0, 1);
      for (int b = 0; b < 9; b++) cycle(1, 16'd9, {24'h0, 8'd127}, '1, 1);
      n_checks++;
      if (o_acc_val10 !== 1'b1 || o_acc10 !== e10 || err10 !== e_err10 || o_busy10 !== 1'b0) begin
         n_fail++;
         $display("FAIL sat10: got val=%b acc=%h err=%h busy=%b want val=1 acc=%h err=%h busy=0",
                  o_acc_val10, o_acc10, err10, o_busy10, e10, e_err10);
      end
      n_checks++;
      if (o_acc !== {60'd0, 20'd1143} || o_acc !== m_acc) begin
         n_fail++;
         $display("FAIL sat20: got %h want %h", o_acc, {60'd0, 20'd1143});
      end
   endtask

   task automatic test_midreset();
      cycle(0, '0, '0, '0, 1);
      cycle(1, 16'd3, rep(8'd10), '1, 1);
      cycle(1, 16'd3, rep(8'd10), '1, 1);
      n_checks++;
      if (o_acc_val !== 1'b0 || o_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pre: got val=%b busy=%b want val=0 busy=1", o_acc_val, o_busy);
      end
      cycle(0, 16'd3, '0, '0, 1);
      n_checks++;
      if (o_busy !== 1'b0 || o_acc_val !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_clear: got busy=%b val=%b want 0 0", o_busy, o_acc_val);
      end
      for (int b = 1; b <= 3; b++) begin
         cycle(1, 16'd3, rep(8'd1), '1, 1);
         n_checks++;
         if (o_acc_val !== logic'(b == 3)) begin
            n_fail++;
            $display("FAIL midrst_val beat%0d: got %b want %b", b, o_acc_val, b == 3);
         end
      end
      n_checks++;
      if (o_acc !== rep_acc(3) || err !== '0) begin
         n_fail++;
         $display("FAIL midrst_sum: got acc=%h err=%h want acc=%h err=0", o_acc, err, rep_acc(3));
      end
      cycle(1, 16'd3, '0, '0, 1);
      n_checks++;
      if (o_acc_val !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_single: got val=%b want 0", o_acc_val);
      end
   endtask

   task automatic test_back_to_back();
      cycle(0, '0, '0, '0, 1);
      for (int b = 0; b < 10; b++) begin
         cycle(1, (b < 4) ? 16'd0 : 16'd2, (BW*NK)'($urandom), '1, 1);
         n_checks++;
         if (o_acc_val !== m_val || o_acc !== m_acc || o_busy !== m_busy || err !== '0) begin
            n_fail++;
            $display("FAIL b2b beat%0d: got val=%b acc=%h busy=%b err=%h want val=%b acc=%h busy=%b err=0",
                     b, o_acc_val, o_acc, o_busy, err, m_val, m_acc, m_busy);
         end
      end
   endtask

   task automatic test_random();
      logic [NK-1:0] pv;
      int unsigned   sel;
      cycle(0, '0, '0, '0, 1);
      for (int c = 0; c < 400; c++) begin
         sel = $urandom_range(0, 9);
         pv  = (sel < 7) ? '1 : (sel == 7) ? '0 : NK'($urandom);
         cycle(1, LW'($urandom_range(0, 4)), (BW*NK)'($urandom), pv, 1'($urandom_range(0, 3) != 0));
         n_checks++;
         if (o_acc_val !== m_val || o_acc !== m_acc || o_busy !== m_busy || err !== m_err) begin
            n_fail++;
            $display("FAIL random c%0d: got val=%b acc=%h busy=%b err=%h want val=%b acc=%h busy=%b err=%h",
                     c, o_acc_val, o_acc, o_busy, err, m_val, m_acc, m_busy, m_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sum3();
      test_negative();
      test_overrun();
      test_partial();
      test_saturation();
      test_midreset();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
